// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers, one byte per grant.
// Optional macro UART_TX_ARB_CHID_EN: each payload frame is preceded by a channel-ID header frame.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BITLEN       = 8,
    parameter int BUSY_TIMEOUT = 16,
    localparam int IDW         = $clog2(NUM_REQ),
    localparam int TW          = $clog2(BUSY_TIMEOUT + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*BITLEN-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [BITLEN-1:0]          uart_data,
    output logic                       uart_data_ready,
    input  logic                       uart_busy,
    output logic [IDW-1:0]             grant_id,
    output logic                       active,
    output logic                       err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE
`ifdef UART_TX_ARB_CHID_EN
        ,
        S_HDR_LAUNCH,
        S_HDR_WAIT_BUSY,
        S_HDR_WAIT_DONE
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic [BITLEN-1:0]    data_q, data_d;
    logic                 dready_q, dready_d;
    logic [IDW-1:0]       grant_q, grant_d;
    logic [IDW-1:0]       rr_q, rr_d;
    logic                 active_q, active_d;
    logic                 err_q, err_d;
    logic [TW-1:0]        cnt_q, cnt_d;
    logic [IDW:0]         pick_s;
    logic [IDW-1:0]       pick_id_s;
    logic [BITLEN-1:0]    pick_byte_s;
`ifdef UART_TX_ARB_CHID_EN
    logic [BITLEN-1:0]    payload_q, payload_d;
`endif

    // MSB of the result flags a hit; search starts just after the last-served index.
    function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                             input logic [IDW-1:0]     ptr);
        logic [IDW:0] res;
        int           idx;
        res = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (!res[IDW] && v[idx]) begin
                res = {1'b1, IDW'(idx)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign pick_s      = rr_pick(req_valid, rr_q);
    assign pick_id_s   = pick_s[IDW-1:0];
    assign pick_byte_s = req_data[int'(pick_id_s)*BITLEN +: BITLEN];

    // Next-state and output decode for the grant/launch/wait sequence.
    always_comb begin
        state_d     = state_q;
        req_ready_d = '0;
        data_d      = data_q;
        dready_d    = 1'b0;
        grant_d     = grant_q;
        rr_d        = rr_q;
        active_d    = active_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
`ifdef UART_TX_ARB_CHID_EN
        payload_d   = payload_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!uart_busy && pick_s[IDW]) begin
                    req_ready_d[pick_id_s] = 1'b1;
                    grant_d  = pick_id_s;
                    rr_d     = pick_id_s;
                    active_d = 1'b1;
`ifdef UART_TX_ARB_CHID_EN
                    payload_d = pick_byte_s;
                    data_d    = BITLEN'(pick_id_s);
                    state_d   = S_HDR_LAUNCH;
`else
                    data_d    = pick_byte_s;
                    state_d   = S_LAUNCH;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: begin
                dready_d = 1'b1;
                cnt_d    = '0;
                state_d  = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (uart_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == TW'(BUSY_TIMEOUT - 1)) begin
                    err_d    = 1'b1;
                    active_d = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!uart_busy) begin
                    active_d = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    state_d = S_WAIT_DONE;
                end
            end
`ifdef UART_TX_ARB_CHID_EN
            S_HDR_LAUNCH: begin
                dready_d = 1'b1;
                cnt_d    = '0;
                state_d  = S_HDR_WAIT_BUSY;
            end
            S_HDR_WAIT_BUSY: begin
                if (uart_busy) begin
                    state_d = S_HDR_WAIT_DONE;
                end else if (cnt_q == TW'(BUSY_TIMEOUT - 1)) begin
                    err_d    = 1'b1;
                    active_d = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_HDR_WAIT_DONE: begin
                // Header frame finished: swap the held payload onto the uart data bus.
                if (!uart_busy) begin
                    data_d  = payload_q;
                    state_d = S_LAUNCH;
                end else begin
                    state_d = S_HDR_WAIT_DONE;
                end
            end
`endif
            default: begin
                active_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    // State and registered-output update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_ready_q <= '0;
            data_q      <= '0;
            dready_q    <= 1'b0;
            grant_q     <= '0;
            rr_q        <= IDW'(NUM_REQ - 1);
            active_q    <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
`ifdef UART_TX_ARB_CHID_EN
            payload_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            data_q      <= data_d;
            dready_q    <= dready_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            active_q    <= active_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
`ifdef UART_TX_ARB_CHID_EN
            payload_q   <= payload_d;
`endif
        end
    end

    assign req_ready       = req_ready_q;
    assign uart_data       = data_q;
    assign uart_data_ready = dready_q;
    assign grant_id        = grant_q;
    assign active          = active_q;
    assign err_timeout     = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a behavioural uart_tx (BITCYCLE=4, 10-bit frames).
module tb_uart_tx_arbiter;

    localparam int NR       = 4;
    localparam int BL       = 8;
    localparam int TO       = 16;
    localparam int BITCYCLE = 4;
    localparam int FRAME    = 10 * BITCYCLE;
`ifdef UART_TX_ARB_CHID_EN
    localparam int FPG = 2;
`else
    localparam int FPG = 1;
`endif

    logic             clk;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR*BL-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic [BL-1:0]    uart_data;
    logic             uart_data_ready;
    logic             uart_busy;
    logic [1:0]       grant_id;
    logic             active;
    logic             err_timeout;

    uart_tx_arbiter #(.NUM_REQ(NR), .BITLEN(BL), .BUSY_TIMEOUT(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .uart_data       (uart_data),
        .uart_data_ready (uart_data_ready),
        .uart_busy       (uart_busy),
        .grant_id        (grant_id),
        .active          (active),
        .err_timeout     (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // uart_tx model: busy for a full frame, latches data at the end of the start bit.
    logic        m_en;
    logic        ext_busy;
    logic        m_busy;
    int          m_cnt;
    logic [7:0]  latched_q[$];
    assign uart_busy = ext_busy | m_busy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end else if (!m_busy) begin
            if (m_en && uart_data_ready) begin
                m_busy <= 1'b1;
                m_cnt  <= 0;
            end
        end else begin
            if (m_cnt == BITCYCLE - 1) latched_q.push_back(uart_data);
            if (m_cnt == FRAME - 1) m_busy <= 1'b0;
            m_cnt <= m_cnt + 1;
        end
    end

    // Grant monitor: logs every accept pulse and flags non-one-hot or grant mismatches.
    int grant_log[$];
    int onehot_err = 0;
    int dready_cnt = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (req_ready != '0) begin
                grant_log.push_back(int'(grant_id));
                if (req_ready != (4'b0001 << grant_id)) onehot_err <= onehot_err + 1;
            end
            if (uart_data_ready) dready_cnt <= dready_cnt + 1;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    logic [7:0] exp_q[$];
    int         f_cur = 0;

    task automatic push_exp(input int id, input logic [7:0] b);
        if (FPG == 2) exp_q.push_back(8'(id));
        exp_q.push_back(b);
    endtask

    task automatic cmp_frames(input string tag);
        check_eq({tag, "_nframes"}, latched_q.size(), exp_q.size());
        for (int i = f_cur; i < exp_q.size(); i++) begin
            if (i < latched_q.size()) check_eq({tag, "_frame"}, latched_q[i], exp_q[i]);
        end
        f_cur = exp_q.size();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (!active && !uart_busy) done = 1'b1;
        end
        check_eq({tag, "_idle"}, done, 1);
    endtask

    task automatic send_one(input int id, input logic [7:0] b, input string tag);
        bit seen = 1'b0;
        @(posedge clk); #1;
        req_data[id*BL +: BL] = b;
        req_valid[id] = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (req_ready[id]) seen = 1'b1;
        end
        check_eq({tag, "_ready"}, seen, 1);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        push_exp(id, b);
        wait_idle(tag, 300);
        cmp_frames(tag);
    endtask

    function automatic logic [7:0] first_byte(input int id, input logic [7:0] b);
        return (FPG == 2) ? 8'(id) : b;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_ready"}, req_ready, 0);
        check_eq({tag, "_uart_data"}, uart_data, 0);
        check_eq({tag, "_data_ready"}, uart_data_ready, 0);
        check_eq({tag, "_grant_id"}, grant_id, 0);
        check_eq({tag, "_active"}, active, 0);
        check_eq({tag, "_err"}, err_timeout, 0);
    endtask

    int base_g;
    int base_d;
    bit hit;

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; m_en = 1'b1; ext_busy = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1 rst = 1'b0;

        // T2: single requester 2 with 8'hA5
        base_g = grant_log.size(); base_d = dready_cnt;
        @(posedge clk); #1;
        req_data[23:16] = 8'hA5; req_valid = 4'b0100;
        @(posedge clk); @(negedge clk);
        check_eq("t2_req_ready", req_ready, 4'b0100);
        check_eq("t2_grant_id", grant_id, 2);
        check_eq("t2_active", active, 1);
        check_eq("t2_uart_data", uart_data, first_byte(2, 8'hA5));
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        check_eq("t2_data_ready", uart_data_ready, 1);
        push_exp(2, 8'hA5);
        wait_idle("t2", 300);
        cmp_frames("t2");
        check_eq("t2_grants", grant_log.size() - base_g, 1);
        check_eq("t2_dready_cnt", dready_cnt - base_d, FPG);

        // T1: reset asserted while the frame is in WAIT_DONE
        @(posedge clk); #1;
        req_data[23:16] = 8'h5E; req_valid = 4'b0100;
        @(posedge clk); #1 req_valid = '0;
        push_exp(2, 8'h5E);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (latched_q.size() >= exp_q.size()) hit = 1'b1;
        end
        check_eq("t1_reached_done", hit, 1);
        check_eq("t1_busy_active", {uart_busy, active}, 2'b11);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("t1");
        cmp_frames("t1");
        @(posedge clk); #1 rst = 1'b0;

        // T3: all four valid, round-robin from rr_ptr=3
        base_g = grant_log.size();
        @(posedge clk); #1;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10}; req_valid = 4'hF;
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            if (grant_log.size() >= base_g + 5) hit = 1'b1;
        end
        check_eq("t3_five_grants", hit, 1);
        @(posedge clk); #1 req_valid = '0;
        push_exp(0, 8'h10); push_exp(1, 8'h11); push_exp(2, 8'h12);
        push_exp(3, 8'h13); push_exp(0, 8'h10);
        wait_idle("t3", 300);
        cmp_frames("t3");
        check_eq("t3_grant_count", grant_log.size() - base_g, 5);
        for (int i = 0; i < 5; i++) begin
            if (base_g + i < grant_log.size()) check_eq("t3_order", grant_log[base_g + i], i % 4);
        end

        // T4: uart_tx never responds -> timeout, byte dropped
        m_en = 1'b0;
        base_d = dready_cnt; base_g = grant_log.size();
        @(posedge clk); #1;
        req_data[15:8] = 8'hC3; req_valid = 4'b0010;
        @(posedge clk); #1 req_valid = '0;
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            @(negedge clk);
            if (uart_data_ready) hit = 1'b1;
        end
        check_eq("t4_data_ready_seen", hit, 1);
        repeat (15) @(negedge clk);
        check_eq("t4_err_before", err_timeout, 0);
        check_eq("t4_active_before", active, 1);
        @(negedge clk);
        check_eq("t4_err_after", err_timeout, 1);
        check_eq("t4_active_after", active, 0);
        check_eq("t4_dready_cnt", dready_cnt - base_d, 1);
        check_eq("t4_grant", grant_log[grant_log.size() - 1], 1);
        cmp_frames("t4");
        m_en = 1'b1;
        send_one(0, 8'h77, "t4_next");
        check_eq("t4_err_sticky", err_timeout, 1);

        // T5: external busy holds off arbitration
        ext_busy = 1'b1;
        base_g = grant_log.size();
        @(posedge clk); #1;
        req_data[7:0] = 8'h3C; req_valid = 4'b0001;
        repeat (10) @(negedge clk);
        check_eq("t5_no_grant", grant_log.size() - base_g, 0);
        @(posedge clk); #1 ext_busy = 1'b0;
        @(posedge clk); @(negedge clk);
        check_eq("t5_req_ready", req_ready, 4'b0001);
        @(posedge clk); #1 req_valid = '0;
        push_exp(0, 8'h3C);
        wait_idle("t5", 300);
        cmp_frames("t5");

`ifdef UART_TX_ARB_CHID_EN
        // T6: header frame carrying the channel ID precedes the payload
        base_g = grant_log.size();
        send_one(3, 8'h5A, "t6");
        check_eq("t6_grants", grant_log.size() - base_g, 1);
`endif

        check_eq("onehot_errors", onehot_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
